// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, winner-detector status codes
// and the drop controller FSM state encoding.
package connect4_pkg;

    localparam int ROWS  = 4;
    localparam int CELLS = 16;

    typedef enum logic [1:0] {
        still_playing = 2'b00,
        p1_wins       = 2'b01,
        p2_wins       = 2'b10,
        tie           = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEARCH    = 3'd1,
        PLACE     = 3'd2,
        SETTLE    = 3'd3,
        DONE      = 3'd4,
        REJECT    = 3'd5,
        GAME_OVER = 3'd6
    } state_t;

endpackage

// File: rtl/drop_controller_if.sv
// Move handshake, board and status signals between the drop controller and its parent.
// move_valid/move_ready: a move is taken on a rising edge where both are high; move_col must be stable with move_valid.
interface drop_controller_if;
    import connect4_pkg::*;

    logic             new_game;
    logic             move_valid;
    logic [1:0]       move_col;
    logic             move_ready;
    status_t          game_status;
    logic [CELLS-1:0] game_board;
    logic [CELLS-1:0] player_cells;
    logic             current_player;
    logic             move_done;
    logic             move_reject;
    logic             game_over;
    state_t           state_dbg;

    modport slave (
        input  new_game, move_valid, move_col, game_status,
        output move_ready, game_board, player_cells, current_player,
               move_done, move_reject, game_over, state_dbg
    );

    modport master (
        output new_game, move_valid, move_col, game_status,
        input  move_ready, game_board, player_cells, current_player,
               move_done, move_reject, game_over, state_dbg
    );
endinterface

// File: rtl/drop_controller.sv
// Connect-4 piece drop controller: searches a column bottom-up, places the piece,
// waits for the external winner detector, then reports done/reject/game over.
module drop_controller
    import connect4_pkg::*;
#(
    parameter int COLS = 4
)
(
    input  logic         clk,
    input  logic         rst,
    drop_controller_if.slave ctl
);

    localparam int IDX_W = $clog2(CELLS);

    state_t           state_q, state_nx;
    logic [CELLS-1:0] board_q, cells_q;
    logic [1:0]       col_q, row_q;
    logic             settle_q;
    logic             player_q;
    logic [IDX_W-1:0] idx;
    logic             cell_full, at_top, playing;

    assign idx       = IDX_W'(int'(row_q) * COLS + int'(col_q));
    assign cell_full = board_q[idx];
    assign at_top    = (row_q == 2'(ROWS - 1));
    assign playing   = (ctl.game_status == still_playing);

    always_ff @(posedge clk) begin
        if (rst || ctl.new_game) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:      if (ctl.move_valid) state_nx = SEARCH;
            SEARCH: begin
                if (!cell_full)  state_nx = PLACE;
                else if (at_top) state_nx = REJECT;
            end
            PLACE:     state_nx = SETTLE;
            // Two cycles so the registered detector sees the new board before DONE samples it
            SETTLE:    if (settle_q) state_nx = DONE;
            DONE:      state_nx = playing ? IDLE : GAME_OVER;
            REJECT:    state_nx = IDLE;
            GAME_OVER: state_nx = GAME_OVER;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || ctl.new_game) begin
            board_q  <= '0;
            cells_q  <= '0;
            player_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            settle_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctl.move_valid) begin
                        col_q <= ctl.move_col;
                        row_q <= '0;
                    end
                end
                SEARCH: begin
                    if (cell_full && !at_top) row_q <= row_q + 2'd1;
                end
                PLACE: begin
                    if (!cell_full) begin
                        board_q[idx] <= 1'b1;
                        cells_q[idx] <= player_q;
                    end
                    settle_q <= 1'b0;
                end
                SETTLE: settle_q <= 1'b1;
                DONE: begin
                    if (playing) player_q <= ~player_q;
                end
                default: ;
            endcase
        end
    end

    assign ctl.move_ready     = (state_q == IDLE);
    assign ctl.move_done      = (state_q == DONE);
    assign ctl.move_reject    = (state_q == REJECT);
    assign ctl.game_over      = (state_q == GAME_OVER);
    assign ctl.game_board     = board_q;
    assign ctl.player_cells   = cells_q;
    assign ctl.current_player = player_q;
    assign ctl.state_dbg      = state_q;

endmodule
